// File: rtl/ppu_timing_if.sv
// ppu_timing_if: register-side controls and timing outputs of the PPU dot/scanline generator
interface ppu_timing_if;
  logic       i_nmi_enable;
  logic       i_rendering_enabled;
  logic       i_status_read;
  logic [8:0] o_dot;
  logic [8:0] o_scanline;
  logic       o_vblank;
  logic       o_int_n;
  logic       o_visible;
  logic       o_frame_start;
  logic       o_odd_frame;
  modport master (
    output i_nmi_enable, i_rendering_enabled, i_status_read,
    input  o_dot, o_scanline, o_vblank, o_int_n, o_visible, o_frame_start, o_odd_frame
  );
  modport slave (
    input  i_nmi_enable, i_rendering_enabled, i_status_read,
    output o_dot, o_scanline, o_vblank, o_int_n, o_visible, o_frame_start, o_odd_frame
  );
endinterface

// File: rtl/ppu_timing.sv
// ppu_timing: NES PPU dot/scanline counters, odd-frame skip, vblank flag and NMI generation
module ppu_timing #(
  parameter int H_DOTS         = 341,
  parameter int V_LINES        = 262,
  parameter int VBLANK_LINE    = 241,
  parameter int PRERENDER_LINE = 261
) (
  input logic          i_clk,
  input logic          i_reset,
  ppu_timing_if.slave  bus
);
  logic [8:0] dot_q, dot_d, scan_q, scan_d;
  logic       vbl_q, vbl_d, odd_q, odd_d, fs_q, fs_d;
  logic       skip, dot_wrap, frame_wrap, vbl_set, vbl_clr;
  always_comb begin
    skip       = scan_q == 9'(PRERENDER_LINE) && dot_q == 9'(H_DOTS - 2) && odd_q && bus.i_rendering_enabled;
    dot_wrap   = dot_q == 9'(H_DOTS - 1) || skip;
    frame_wrap = dot_wrap && (scan_q == 9'(V_LINES - 1) || skip);
    dot_d      = dot_wrap ? 9'd0 : dot_q + 9'd1;
    scan_d     = frame_wrap ? 9'd0 : dot_wrap ? scan_q + 9'd1 : scan_q;
    odd_d      = odd_q ^ frame_wrap;
    fs_d       = frame_wrap;
    vbl_set    = scan_q == 9'(VBLANK_LINE) && dot_q == 9'd0;
    // a status read in the set cycle wins, which is how the read/set race suppresses NMI
    vbl_clr    = (scan_q == 9'(PRERENDER_LINE) && dot_q == 9'd0) || bus.i_status_read;
    vbl_d      = vbl_clr ? 1'b0 : vbl_set ? 1'b1 : vbl_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dot_q  <= '0;
      scan_q <= '0;
      vbl_q  <= 1'b0;
      odd_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      dot_q  <= dot_d;
      scan_q <= scan_d;
      vbl_q  <= vbl_d;
      odd_q  <= odd_d;
      fs_q   <= fs_d;
    end
  end
  assign bus.o_dot         = dot_q;
  assign bus.o_scanline    = scan_q;
  assign bus.o_vblank      = vbl_q;
  assign bus.o_int_n       = ~(vbl_q & bus.i_nmi_enable);
  assign bus.o_visible     = scan_q < 9'd240 && dot_q >= 9'd1 && dot_q <= 9'd256;
  assign bus.o_frame_start = fs_q;
  assign bus.o_odd_frame   = odd_q;
endmodule

// File: tb/tb_ppu_timing.sv
// tb_ppu_timing: directed checks of counters, frame skip, vblank/NMI and reset on a shortened frame
module tb_ppu_timing;
  localparam int H  = 341;
  localparam int V  = 20;
  localparam int VB = 12;
  localparam int PR = 19;
  localparam int F  = H * V;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int n, m;
  ppu_timing_if b ();
  ppu_timing #(.H_DOTS(H), .V_LINES(V), .VBLANK_LINE(VB), .PRERENDER_LINE(PR)) dut (
    .i_clk(clk), .i_reset(rst), .bus(b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic goto(input int l, input int d, output int k);
    k = 0;
    while (!(int'(b.o_scanline) == l && int'(b.o_dot) == d) && k < 100000) begin
      tick();
      k++;
    end
    if (k >= 100000) begin
      n_err++;
      $display("FAIL goto(%0d,%0d) timeout", l, d);
    end
  endtask
  task automatic wait_fs(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!b.o_frame_start && k < 100000);
    if (k >= 100000) begin
      n_err++;
      $display("FAIL wait_fs timeout");
    end
  endtask
  initial begin
    b.i_nmi_enable = 1'b0;
    b.i_rendering_enabled = 1'b0;
    b.i_status_read = 1'b0;
    repeat (2) tick();
    chk("rst_dot", b.o_dot, 0);
    chk("rst_scan", b.o_scanline, 0);
    chk("rst_vbl", b.o_vblank, 0);
    chk("rst_int_n", b.o_int_n, 1);
    chk("rst_odd", b.o_odd_frame, 0);
    chk("rst_fs", b.o_frame_start, 0);
    rst = 1'b0;
    wait_fs(n);
    chk("frame0_len", n, F);
    chk("frame0_dot", b.o_dot, 0);
    chk("frame0_scan", b.o_scanline, 0);
    chk("frame0_odd", b.o_odd_frame, 1);
    tick();
    chk("fs_one_cycle", b.o_frame_start, 0);
    wait_fs(n);
    chk("frame1_len", n + 1, F);
    chk("frame1_odd", b.o_odd_frame, 0);
    chk("vis_00", b.o_visible, 0);
    tick();
    chk("vis_01", b.o_visible, 1);
    goto(5, 256, n);
    chk("vis_256", b.o_visible, 1);
    tick();
    chk("vis_257", b.o_visible, 0);
    b.i_nmi_enable = 1'b1;
    goto(VB, 0, n);
    chk("pre_set_vbl", b.o_vblank, 0);
    chk("pre_set_int", b.o_int_n, 1);
    tick();
    chk("set_vbl", b.o_vblank, 1);
    chk("set_int", b.o_int_n, 0);
    goto(PR, 0, n);
    chk("pr0_vbl", b.o_vblank, 1);
    tick();
    chk("vbl_dur", n + 1, (PR - VB) * H);
    chk("clr_vbl", b.o_vblank, 0);
    chk("clr_int", b.o_int_n, 1);
    b.i_nmi_enable = 1'b0;
    goto(VB + 1, 5, n);
    chk("nmi_off_vbl", b.o_vblank, 1);
    chk("nmi_off_int", b.o_int_n, 1);
    b.i_nmi_enable = 1'b1;
    #1;
    chk("nmi_rise_int", b.o_int_n, 0);
    b.i_nmi_enable = 1'b0;
    #1;
    chk("nmi_fall_int", b.o_int_n, 1);
    b.i_nmi_enable = 1'b1;
    goto(VB + 2, 10, n);
    b.i_status_read = 1'b1;
    tick();
    b.i_status_read = 1'b0;
    chk("sr_clr_vbl", b.o_vblank, 0);
    chk("sr_clr_int", b.o_int_n, 1);
    goto(VB, 0, n);
    b.i_status_read = 1'b1;
    tick();
    b.i_status_read = 1'b0;
    chk("race_vbl", b.o_vblank, 0);
    goto(PR - 1, 0, n);
    chk("race_vbl_late", b.o_vblank, 0);
    chk("race_int_late", b.o_int_n, 1);
    rst = 1'b1;
    b.i_rendering_enabled = 1'b1;
    tick();
    rst = 1'b0;
    wait_fs(n);
    chk("ren_even_len", n, F);
    goto(PR, H - 2, n);
    tick();
    chk("ren_odd_len", n + 1, F - 1);
    chk("skip_dot", b.o_dot, 0);
    chk("skip_scan", b.o_scanline, 0);
    chk("skip_fs", b.o_frame_start, 1);
    chk("skip_odd", b.o_odd_frame, 0);
    goto(PR, H - 1, m);
    tick();
    chk("ren_even2_len", m + 1, F);
    chk("even2_fs", b.o_frame_start, 1);
    b.i_rendering_enabled = 1'b0;
    goto(VB + 3, 100, n);
    chk("mid_vbl", b.o_vblank, 1);
    chk("mid_int", b.o_int_n, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_dot", b.o_dot, 0);
    chk("mrst_scan", b.o_scanline, 0);
    chk("mrst_vbl", b.o_vblank, 0);
    chk("mrst_int", b.o_int_n, 1);
    chk("mrst_odd", b.o_odd_frame, 0);
    chk("mrst_fs", b.o_frame_start, 0);
    tick();
    chk("resume_dot", b.o_dot, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
